// File: rtl/rvh_lsu_ld_req_issue.sv
// LSU load-request issue queue: holds dispatched loads, issues them in index
// order to the L1D bank load pipe, retires on writeback and re-arms on replay.
module rvh_lsu_ld_req_issue #(
  parameter int LDQ_DEPTH      = 4,
  parameter int PADDR_WIDTH    = 56,
  parameter int ROB_TAG_WIDTH  = 4,
  parameter int PREG_TAG_WIDTH = 4,
  parameter int LSU_ID_WIDTH   = 12,
  parameter int REQ_TYPE_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          ld_alloc_vld_i,
  output logic                          ld_alloc_rdy_o,
  input  logic [ROB_TAG_WIDTH-1:0]      ld_alloc_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0]     ld_alloc_prd_i,
  input  logic [PADDR_WIDTH-1:0]        ld_alloc_paddr_i,
  input  logic [REQ_TYPE_WIDTH-1:0]     ld_alloc_req_type_dec_i,
  output logic                          ls_pipe_l1d_ld_req_vld_o,
  input  logic                          ls_pipe_l1d_ld_req_rdy_i,
  output logic [ROB_TAG_WIDTH-1:0]      ls_pipe_l1d_ld_req_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0]     ls_pipe_l1d_ld_req_prd_o,
  output logic [LSU_ID_WIDTH-1:0]       ls_pipe_l1d_ld_req_lsu_tag_o,
  output logic [PADDR_WIDTH-1:0]        ls_pipe_l1d_ld_req_paddr_o,
  output logic [5:0]                    ls_pipe_l1d_ld_req_offset_o,
  output logic [REQ_TYPE_WIDTH-1:0]     ls_pipe_l1d_ld_req_type_dec_o,
  input  logic                          l1d_lsu_resp_vld_i,
  input  logic [LSU_ID_WIDTH-1:0]       l1d_lsu_lsu_tag_i,
  input  logic                          l1d_lsu_replay_vld_i,
  input  logic [LSU_ID_WIDTH-1:0]       l1d_lsu_replay_lsu_tag_i,
  output logic [$clog2(LDQ_DEPTH):0]    ldq_outstanding_cnt_o,
  output logic                          ldq_empty_o
);

  localparam int IDX_W = $clog2(LDQ_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } ent_state_e;

  ent_state_e                 st_q    [LDQ_DEPTH];
  ent_state_e                 st_d    [LDQ_DEPTH];
  logic [ROB_TAG_WIDTH-1:0]   rob_q   [LDQ_DEPTH];
  logic [PREG_TAG_WIDTH-1:0]  prd_q   [LDQ_DEPTH];
  logic [PADDR_WIDTH-1:0]     paddr_q [LDQ_DEPTH];
  logic [REQ_TYPE_WIDTH-1:0]  type_q  [LDQ_DEPTH];
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic             any_free, any_wait;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             alloc_fire, issue_fire;

  // Lowest-index FREE and WAIT entries; scanning downwards lets the lowest win.
  always_comb begin
    any_free = 1'b0;
    any_wait = 1'b0;
    free_idx = '0;
    sel_idx  = '0;
    for (int i = LDQ_DEPTH - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (st_q[i] == ST_WAIT) begin
        any_wait = 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign ld_alloc_rdy_o           = any_free & ~flush_i;
  assign ls_pipe_l1d_ld_req_vld_o = any_wait & ~flush_i;
  assign alloc_fire = ld_alloc_vld_i & ld_alloc_rdy_o;
  assign issue_fire = ls_pipe_l1d_ld_req_vld_o & ls_pipe_l1d_ld_req_rdy_i;

  // Per-entry transitions; a response outranks a replay on the same tag.
  // Tags beyond the queue simply match no entry.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < LDQ_DEPTH; i++) begin
      st_d[i] = st_q[i];
      if (flush_i) begin
        st_d[i] = ST_FREE;
      end else begin
        case (st_q[i])
          ST_FREE: begin
            if (alloc_fire && free_idx == IDX_W'(i)) st_d[i] = ST_WAIT;
          end
          ST_WAIT: begin
            if (issue_fire && sel_idx == IDX_W'(i)) st_d[i] = ST_ISSUED;
          end
          ST_ISSUED: begin
            if (l1d_lsu_resp_vld_i && l1d_lsu_lsu_tag_i == LSU_ID_WIDTH'(i))
              st_d[i] = ST_FREE;
            else if (l1d_lsu_replay_vld_i && l1d_lsu_replay_lsu_tag_i == LSU_ID_WIDTH'(i))
              st_d[i] = ST_WAIT;
          end
          default: st_d[i] = ST_FREE;
        endcase
      end
      if (st_d[i] != ST_FREE) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LDQ_DEPTH; i++) st_q[i] <= ST_FREE;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < LDQ_DEPTH; i++) st_q[i] <= st_d[i];
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        rob_q[i]   <= '0;
        prd_q[i]   <= '0;
        paddr_q[i] <= '0;
        type_q[i]  <= '0;
      end
    end else if (alloc_fire) begin
      rob_q[free_idx]   <= ld_alloc_rob_tag_i;
      prd_q[free_idx]   <= ld_alloc_prd_i;
      paddr_q[free_idx] <= ld_alloc_paddr_i;
      type_q[free_idx]  <= ld_alloc_req_type_dec_i;
    end
  end

  // Request fields come only from registered entries, never from the alloc port.
  assign ls_pipe_l1d_ld_req_rob_tag_o  = rob_q[sel_idx];
  assign ls_pipe_l1d_ld_req_prd_o      = prd_q[sel_idx];
  assign ls_pipe_l1d_ld_req_lsu_tag_o  = LSU_ID_WIDTH'(sel_idx);
  assign ls_pipe_l1d_ld_req_paddr_o    = paddr_q[sel_idx];
  assign ls_pipe_l1d_ld_req_offset_o   = paddr_q[sel_idx][5:0];
  assign ls_pipe_l1d_ld_req_type_dec_o = type_q[sel_idx];

  assign ldq_outstanding_cnt_o = cnt_q;
  assign ldq_empty_o           = (cnt_q == '0);

endmodule

// File: tb/tb_rvh_lsu_ld_req_issue.sv
// Directed bench for rvh_lsu_ld_req_issue: an entry-level reference model is
// compared every cycle, plus literal expectations at key points.
module tb_rvh_lsu_ld_req_issue;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        alloc_vld = 1'b0;
  logic        alloc_rdy;
  logic [3:0]  alloc_rob = '0;
  logic [3:0]  alloc_prd = '0;
  logic [55:0] alloc_paddr = '0;
  logic [13:0] alloc_type = '0;
  logic        req_vld;
  logic        req_rdy = 1'b0;
  logic [3:0]  req_rob, req_prd;
  logic [11:0] req_tag;
  logic [55:0] req_paddr;
  logic [5:0]  req_off;
  logic [13:0] req_type;
  logic        resp_vld = 1'b0;
  logic [11:0] resp_tag = '0;
  logic        rply_vld = 1'b0;
  logic [11:0] rply_tag = '0;
  logic [2:0]  cnt;
  logic        empty;

  int vec = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  rvh_lsu_ld_req_issue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ld_alloc_vld_i(alloc_vld), .ld_alloc_rdy_o(alloc_rdy),
    .ld_alloc_rob_tag_i(alloc_rob), .ld_alloc_prd_i(alloc_prd),
    .ld_alloc_paddr_i(alloc_paddr), .ld_alloc_req_type_dec_i(alloc_type),
    .ls_pipe_l1d_ld_req_vld_o(req_vld), .ls_pipe_l1d_ld_req_rdy_i(req_rdy),
    .ls_pipe_l1d_ld_req_rob_tag_o(req_rob), .ls_pipe_l1d_ld_req_prd_o(req_prd),
    .ls_pipe_l1d_ld_req_lsu_tag_o(req_tag), .ls_pipe_l1d_ld_req_paddr_o(req_paddr),
    .ls_pipe_l1d_ld_req_offset_o(req_off), .ls_pipe_l1d_ld_req_type_dec_o(req_type),
    .l1d_lsu_resp_vld_i(resp_vld), .l1d_lsu_lsu_tag_i(resp_tag),
    .l1d_lsu_replay_vld_i(rply_vld), .l1d_lsu_replay_lsu_tag_i(rply_tag),
    .ldq_outstanding_cnt_o(cnt), .ldq_empty_o(empty)
  );

  always #5 clk = ~clk;

  // Reference model: an entry is either unused, holding-but-not-sent, or sent.
  bit          m_busy [D] = '{default: 1'b0};
  bit          m_sent [D] = '{default: 1'b0};
  logic [3:0]  m_rob  [D] = '{default: '0};
  logic [3:0]  m_prd  [D] = '{default: '0};
  logic [55:0] m_pa   [D] = '{default: '0};
  logic [13:0] m_ty   [D] = '{default: '0};

  function automatic int first_free();
    for (int i = 0; i < D; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int first_pending();
    for (int i = 0; i < D; i++) if (m_busy[i] && !m_sent[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < D; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush_i) begin
      for (int i = 0; i < D; i++) begin
        m_busy[i] <= 1'b0;
        m_sent[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < D; i++) begin
        if (m_busy[i] && m_sent[i]) begin
          if (resp_vld && resp_tag == 12'(i)) m_busy[i] <= 1'b0;
          else if (rply_vld && rply_tag == 12'(i)) m_sent[i] <= 1'b0;
        end
      end
      if (req_rdy && first_pending() >= 0) m_sent[first_pending()] <= 1'b1;
      if (alloc_vld && first_free() >= 0) begin
        m_busy[first_free()] <= 1'b1;
        m_sent[first_free()] <= 1'b0;
        m_rob[first_free()]  <= alloc_rob;
        m_prd[first_free()]  <= alloc_prd;
        m_pa[first_free()]   <= alloc_paddr;
        m_ty[first_free()]   <= alloc_type;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int p;
    if (chk_en) begin
      p = first_pending();
      chk("m_alloc_rdy", 64'(alloc_rdy), 64'((first_free() >= 0) && !flush_i));
      chk("m_req_vld", 64'(req_vld), 64'((p >= 0) && !flush_i));
      chk("m_cnt", 64'(cnt), 64'(busy_count()));
      chk("m_empty", 64'(empty), 64'(busy_count() == 0));
      if (p >= 0 && !flush_i) begin
        chk("m_tag", 64'(req_tag), 64'(p));
        chk("m_rob", 64'(req_rob), 64'(m_rob[p]));
        chk("m_prd", 64'(req_prd), 64'(m_prd[p]));
        chk("m_paddr", 64'(req_paddr), 64'(m_pa[p]));
        chk("m_off", 64'(req_off), 64'(m_pa[p][5:0]));
        chk("m_type", 64'(req_type), 64'(m_ty[p]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic [3:0] rob, input logic [3:0] prd,
                           input logic [55:0] pa, input logic [13:0] ty);
    alloc_vld = 1'b1; alloc_rob = rob; alloc_prd = prd; alloc_paddr = pa; alloc_type = ty;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_rdy", 64'(alloc_rdy), 64'd1);
    chk("rst_vld", 64'(req_vld), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);

    // single load round trip
    cyc();
    set_alloc(4'd3, 4'd5, 56'h1048, 14'h1234);
    cyc();
    alloc_vld = 1'b0;
    #1;
    chk("t1_vld", 64'(req_vld), 64'd1);
    chk("t1_tag", 64'(req_tag), 64'd0);
    chk("t1_off", 64'(req_off), 64'h08);
    chk("t1_rob", 64'(req_rob), 64'd3);
    chk("t1_prd", 64'(req_prd), 64'd5);
    req_rdy = 1'b1;
    cyc();
    req_rdy = 1'b0;
    #1;
    chk("t1_issued_vld", 64'(req_vld), 64'd0);
    chk("t1_issued_cnt", 64'(cnt), 64'd1);
    resp_vld = 1'b1; resp_tag = 12'd0;
    cyc();
    resp_vld = 1'b0;
    #1;
    chk("t1_done_cnt", 64'(cnt), 64'd0);
    chk("t1_done_empty", 64'(empty), 64'd1);

    // fill the queue while the bank stalls
    for (int k = 0; k < 4; k++) begin
      set_alloc(4'(k + 8), 4'(k + 1), 56'h2000 + 56'(k * 'h44), 14'(14'h100 + k));
      cyc();
    end
    #1;
    chk("t2_full_rdy", 64'(alloc_rdy), 64'd0);
    chk("t2_full_cnt", 64'(cnt), 64'd4);
    set_alloc(4'd15, 4'd15, 56'hdead, 14'h3fff);
    cyc();
    alloc_vld = 1'b0;
    #1;
    chk("t2_5th_cnt", 64'(cnt), 64'd4);
    chk("t2_hold_tag", 64'(req_tag), 64'd0);
    chk("t2_hold_rob", 64'(req_rob), 64'd8);

    // issue 0 and 1, replay 1
    req_rdy = 1'b1;
    cyc(); cyc();
    req_rdy = 1'b0;
    #1;
    chk("t3_sel2", 64'(req_tag), 64'd2);
    rply_vld = 1'b1; rply_tag = 12'd1;
    cyc();
    rply_vld = 1'b0;
    #1;
    chk("t3_rply_tag", 64'(req_tag), 64'd1);
    chk("t3_rply_rob", 64'(req_rob), 64'd9);
    chk("t3_rply_off", 64'(req_off), 64'h04);
    chk("t3_rply_paddr", 64'(req_paddr), 64'h2044);
    req_rdy = 1'b1;
    cyc();
    req_rdy = 1'b0;
    resp_vld = 1'b1; resp_tag = 12'd1;
    cyc();
    resp_vld = 1'b0;
    #1;
    chk("t3_cnt", 64'(cnt), 64'd3);

    // response+replay together on tag 2; spurious responses
    req_rdy = 1'b1;
    cyc();
    req_rdy = 1'b0;
    resp_vld = 1'b1; resp_tag = 12'd2;
    rply_vld = 1'b1; rply_tag = 12'd2;
    cyc();
    rply_vld = 1'b0;
    #1;
    chk("t4_cnt", 64'(cnt), 64'd2);
    chk("t4_tag", 64'(req_tag), 64'd3);
    resp_tag = 12'd2;
    cyc();
    resp_tag = 12'd3;
    cyc();
    resp_tag = 12'd5;
    cyc();
    resp_vld = 1'b0;
    #1;
    chk("t4_spur_cnt", 64'(cnt), 64'd2);
    chk("t4_spur_vld", 64'(req_vld), 64'd1);

    // flush with mixed states and a competing alloc
    set_alloc(4'd1, 4'd2, 56'h3f, 14'd7);
    cyc();
    alloc_vld = 1'b0;
    #1;
    chk("t5_pre_cnt", 64'(cnt), 64'd3);
    chk("t5_pre_tag", 64'(req_tag), 64'd1);
    flush_i = 1'b1;
    set_alloc(4'd6, 4'd6, 56'h66, 14'd6);
    req_rdy = 1'b1;
    resp_vld = 1'b1; resp_tag = 12'd0;
    #1;
    chk("t5_fl_rdy", 64'(alloc_rdy), 64'd0);
    chk("t5_fl_vld", 64'(req_vld), 64'd0);
    cyc();
    flush_i = 1'b0; alloc_vld = 1'b0; req_rdy = 1'b0;
    #1;
    chk("t5_post_cnt", 64'(cnt), 64'd0);
    chk("t5_post_empty", 64'(empty), 64'd1);
    resp_tag = 12'd0;
    cyc();
    resp_vld = 1'b0;
    #1;
    chk("t5_late_cnt", 64'(cnt), 64'd0);

    // asynchronous reset in the middle of a stall
    set_alloc(4'd2, 4'd3, 56'h1100, 14'd1);
    cyc();
    set_alloc(4'd4, 4'd5, 56'h1200, 14'd2);
    cyc();
    alloc_vld = 1'b0;
    #1;
    chk("t6_pre_cnt", 64'(cnt), 64'd2);
    chk("t6_pre_vld", 64'(req_vld), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_vld", 64'(req_vld), 64'd0);
    chk("t6_async_cnt", 64'(cnt), 64'd0);
    chk("t6_async_empty", 64'(empty), 64'd1);
    cyc(); cyc();
    rst = 1'b0;
    resp_vld = 1'b1; resp_tag = 12'd0;
    cyc();
    resp_vld = 1'b0;
    #1;
    chk("t6_late_cnt", 64'(cnt), 64'd0);
    set_alloc(4'd7, 4'd7, 56'h77, 14'd3);
    cyc();
    alloc_vld = 1'b0;
    #1;
    chk("t6_realloc_tag", 64'(req_tag), 64'd0);
    chk("t6_realloc_rob", 64'(req_rob), 64'd7);
    cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
